ascii_sum_ctrl: RTL and testbench

//  Sequencer for the ASCII adder datapath. Collects four ASCII decimal digits

---
 rtl/ascii_sum_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_ascii_sum_ctrl.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ascii_sum_ctrl.sv
// Sequencer for the ASCII adder: collects A/B tens and units digits and drives a shared
// ASCII->binary converter for each operand, then adds. Optional macro SUM_ASCII_EN adds the sum's ASCII digits.
module ascii_sum_ctrl #(
  parameter int unsigned CHAR_W    = 7,
  parameter int unsigned CONV_WAIT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CHAR_W-1:0] char_in_i,
  input  logic              char_valid_i,
  output logic              char_ready_o,
  output logic [CHAR_W-1:0] conv_au_o,
  output logic [CHAR_W-1:0] conv_ad_o,
  input  logic [6:0]        conv_bin_i,
  output logic [7:0]        sum_o,
  output logic              sum_valid_o,
  input  logic              sum_ready_i,
  output logic              char_err_o
`ifdef SUM_ASCII_EN
  ,
  output logic [CHAR_W-1:0] sum_ascii_h_o,
  output logic [CHAR_W-1:0] sum_ascii_t_o,
  output logic [CHAR_W-1:0] sum_ascii_u_o
`endif
);

  localparam int unsigned BIN_W = 7;
  localparam int unsigned SUM_W = 8;
  localparam int unsigned CNT_W = (CONV_WAIT > 1) ? $clog2(CONV_WAIT) : 1;

  typedef enum logic [2:0] {
    ST_A_TENS,
    ST_A_UNITS,
    ST_B_TENS,
    ST_B_UNITS,
    ST_CONV_A,
    ST_CONV_B,
    ST_ADD,
    ST_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CHAR_W-1:0] a_tens_q, a_tens_d, a_units_q, a_units_d;
  logic [CHAR_W-1:0] b_tens_q, b_tens_d, b_units_q, b_units_d;
  logic [BIN_W-1:0]  a_bin_q, a_bin_d, b_bin_q, b_bin_d;
  logic [CHAR_W-1:0] conv_au_q, conv_au_d, conv_ad_q, conv_ad_d;
  logic [SUM_W-1:0]  sum_q, sum_d;
  logic              sum_valid_q, sum_valid_d;
  logic              char_ready_q, char_ready_d;
  logic              char_err_q, char_err_d;

  logic              xfer_c;
  logic              legal_c;
  logic              wait_done_c;
  logic [SUM_W-1:0]  sum_add_c;

  assign xfer_c      = char_valid_i & char_ready_q;
  assign legal_c     = (char_in_i >= CHAR_W'('h30)) && (char_in_i <= CHAR_W'('h39));
  assign wait_done_c = (cnt_q == CNT_W'(CONV_WAIT - 1));
  assign sum_add_c   = SUM_W'(a_bin_q) + SUM_W'(b_bin_q);

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_A_TENS;
      cnt_q        <= '0;
      a_tens_q     <= '0;
      a_units_q    <= '0;
      b_tens_q     <= '0;
      b_units_q    <= '0;
      a_bin_q      <= '0;
      b_bin_q      <= '0;
      conv_au_q    <= CHAR_W'('h30);
      conv_ad_q    <= CHAR_W'('h30);
      sum_q        <= '0;
      sum_valid_q  <= 1'b0;
      char_ready_q <= 1'b0;
      char_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      a_tens_q     <= a_tens_d;
      a_units_q    <= a_units_d;
      b_tens_q     <= b_tens_d;
      b_units_q    <= b_units_d;
      a_bin_q      <= a_bin_d;
      b_bin_q      <= b_bin_d;
      conv_au_q    <= conv_au_d;
      conv_ad_q    <= conv_ad_d;
      sum_q        <= sum_d;
      sum_valid_q  <= sum_valid_d;
      char_ready_q <= char_ready_d;
      char_err_q   <= char_err_d;
    end
  end

  // Next-state and output decode; converter inputs are loaded on entry to each CONV state
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    a_tens_d    = a_tens_q;
    a_units_d   = a_units_q;
    b_tens_d    = b_tens_q;
    b_units_d   = b_units_q;
    a_bin_d     = a_bin_q;
    b_bin_d     = b_bin_q;
    conv_au_d   = conv_au_q;
    conv_ad_d   = conv_ad_q;
    sum_d       = sum_q;
    sum_valid_d = sum_valid_q;
    char_err_d  = 1'b0;

    case (state_q)
      ST_A_TENS, ST_A_UNITS, ST_B_TENS, ST_B_UNITS: begin
        if (xfer_c && !legal_c) begin
          char_err_d = 1'b1;
          state_d    = ST_A_TENS;
        end else if (xfer_c) begin
          case (state_q)
            ST_A_TENS: begin
              a_tens_d = char_in_i;
              state_d  = ST_A_UNITS;
            end
            ST_A_UNITS: begin
              a_units_d = char_in_i;
              state_d   = ST_B_TENS;
            end
            ST_B_TENS: begin
              b_tens_d = char_in_i;
              state_d  = ST_B_UNITS;
            end
            default: begin
              b_units_d = char_in_i;
              conv_ad_d = a_tens_q;
              conv_au_d = a_units_q;
              state_d   = ST_CONV_A;
            end
          endcase
        end
      end
      ST_CONV_A: begin
        if (wait_done_c) begin
          cnt_d     = '0;
          a_bin_d   = conv_bin_i;
          conv_ad_d = b_tens_q;
          conv_au_d = b_units_q;
          state_d   = ST_CONV_B;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_CONV_B: begin
        if (wait_done_c) begin
          cnt_d   = '0;
          b_bin_d = conv_bin_i;
          state_d = ST_ADD;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_ADD: begin
        sum_d       = sum_add_c;
        sum_valid_d = 1'b1;
        state_d     = ST_DONE;
      end
      ST_DONE: begin
        if (sum_valid_q && sum_ready_i) begin
          sum_valid_d = 1'b0;
          state_d     = ST_A_TENS;
        end
      end
      default: state_d = ST_A_TENS;
    endcase

    char_ready_d = (state_d == ST_A_TENS) || (state_d == ST_A_UNITS) ||
                   (state_d == ST_B_TENS) || (state_d == ST_B_UNITS);
  end

  assign char_ready_o = char_ready_q;
  assign conv_au_o    = conv_au_q;
  assign conv_ad_o    = conv_ad_q;
  assign sum_o        = sum_q;
  assign sum_valid_o  = sum_valid_q;
  assign char_err_o   = char_err_q;

`ifdef SUM_ASCII_EN
  logic [SUM_W-1:0]  dig_h_c, dig_t_c, dig_u_c;
  logic [CHAR_W-1:0] asc_h_q, asc_t_q, asc_u_q;

  assign dig_h_c = sum_add_c / SUM_W'(100);
  assign dig_t_c = (sum_add_c % SUM_W'(100)) / SUM_W'(10);
  assign dig_u_c = sum_add_c % SUM_W'(10);

  // Decimal digits of the sum, captured alongside the binary sum
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      asc_h_q <= CHAR_W'('h30);
      asc_t_q <= CHAR_W'('h30);
      asc_u_q <= CHAR_W'('h30);
    end else if (state_q == ST_ADD) begin
      asc_h_q <= CHAR_W'(dig_h_c) + CHAR_W'('h30);
      asc_t_q <= CHAR_W'(dig_t_c) + CHAR_W'('h30);
      asc_u_q <= CHAR_W'(dig_u_c) + CHAR_W'('h30);
    end
  end

  assign sum_ascii_h_o = asc_h_q;
  assign sum_ascii_t_o = asc_t_q;
  assign sum_ascii_u_o = asc_u_q;
`endif

endmodule

// File: tb/tb_ascii_sum_ctrl.sv
// Self-checking bench for ascii_sum_ctrl: transaction-level reference model compared every cycle,
// plus directed digit sequences with hand-computed sums and random traffic.
module tb_ascii_sum_ctrl;
  localparam int unsigned CHAR_W    = 7;
  localparam int unsigned CONV_WAIT = 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [CHAR_W-1:0] char_in = '0;
  logic              char_valid = 1'b0;
  logic              char_ready;
  logic [CHAR_W-1:0] conv_au, conv_ad;
  logic [6:0]        conv_bin;
  logic [7:0]        sum;
  logic              sum_valid;
  logic              sum_ready = 1'b0;
  logic              char_err;
`ifdef SUM_ASCII_EN
  logic [CHAR_W-1:0] asc_h, asc_t, asc_u;
`endif

  ascii_sum_ctrl #(.CHAR_W(CHAR_W), .CONV_WAIT(CONV_WAIT)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .char_in_i    (char_in),
    .char_valid_i (char_valid),
    .char_ready_o (char_ready),
    .conv_au_o    (conv_au),
    .conv_ad_o    (conv_ad),
    .conv_bin_i   (conv_bin),
    .sum_o        (sum),
    .sum_valid_o  (sum_valid),
    .sum_ready_i  (sum_ready),
    .char_err_o   (char_err)
`ifdef SUM_ASCII_EN
    ,
    .sum_ascii_h_o(asc_h),
    .sum_ascii_t_o(asc_t),
    .sum_ascii_u_o(asc_u)
`endif
  );

  always #5 clk = ~clk;

  // Combinational ASCII-pair to binary converter
  assign conv_bin = 7'((int'(conv_ad) - 48) * 10 + (int'(conv_au) - 48));

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_en = 1'b0;
  int rdy_mode = 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: digits queue, countdown to result, handshake flags
  logic [6:0] m_q[$];
  int         m_busy = 0;
  logic [7:0] m_sum = '0, m_pend = '0;
  bit         m_valid = 1'b0, m_ready = 1'b0, m_err = 1'b0;
  logic [6:0] m_ad = 7'h30, m_au = 7'h30, m_bt = 7'h30, m_bu = 7'h30;

  function automatic bit is_digit(input logic [6:0] c);
    return (c >= 7'h30) && (c <= 7'h39);
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_busy = 0; m_sum = '0; m_valid = 0; m_ready = 0; m_err = 0;
    m_ad = 7'h30; m_au = 7'h30;
  endtask

  task automatic model_step();
    int a, b;
    m_err = 0;
    if (m_busy > 0) begin
      m_busy--;
      if (m_busy == CONV_WAIT + 1) begin
        m_ad = m_bt; m_au = m_bu;
      end
      if (m_busy == 0) begin
        m_sum = m_pend; m_valid = 1;
      end
    end else if (m_valid) begin
      if (sum_ready) m_valid = 0;
    end else if (m_ready && char_valid) begin
      if (is_digit(char_in)) begin
        m_q.push_back(char_in);
        if (m_q.size() == 4) begin
          a = (int'(m_q[0]) - 48) * 10 + (int'(m_q[1]) - 48);
          b = (int'(m_q[2]) - 48) * 10 + (int'(m_q[3]) - 48);
          m_pend = 8'(a + b);
          m_ad = m_q[0]; m_au = m_q[1]; m_bt = m_q[2]; m_bu = m_q[3];
          m_busy = 2 * CONV_WAIT + 1;
          m_q.delete();
        end
      end else begin
        m_q.delete();
        m_err = 1;
      end
    end
    m_ready = (m_busy == 0) && !m_valid;
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) model_reset();
    else model_step();
  end

  // Per-cycle comparison against the model
  initial forever begin
    @(negedge clk);
    if (cmp_en) begin
      chk("char_ready", char_ready, m_ready);
      chk("sum_valid", sum_valid, m_valid);
      chk("sum", sum, m_sum);
      chk("char_err", char_err, m_err);
      chk("conv_ad", conv_ad, m_ad);
      chk("conv_au", conv_au, m_au);
`ifdef SUM_ASCII_EN
      chk("ascii_h", asc_h, 32'(m_sum / 100 + 48));
      chk("ascii_t", asc_t, 32'((m_sum % 100) / 10 + 48));
      chk("ascii_u", asc_u, 32'(m_sum % 10 + 48));
`endif
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    case (rdy_mode)
      0:       sum_ready = 1'($urandom_range(0, 1));
      1:       sum_ready = 1'b1;
      default: sum_ready = 1'b0;
    endcase
  end

  task automatic send_char(input logic [6:0] c, input int gap);
    bit acc;
    acc = 0;
    repeat (gap) begin
      @(posedge clk); #1;
    end
    char_valid = 1'b1;
    char_in    = c;
    for (int i = 0; i < 300; i++) begin
      acc = char_ready;
      @(posedge clk); #1;
      if (acc) break;
    end
    if (!acc) chk("send_timeout", 0, 1);
    char_valid = 1'b0;
  endtask

  task automatic send4(input logic [6:0] c0, c1, c2, c3, input int gap);
    send_char(c0, gap); send_char(c1, gap); send_char(c2, gap); send_char(c3, gap);
  endtask

  task automatic wait_sum(input string nm, input logic [7:0] exp, output int lat);
    bit seen;
    seen = 0;
    lat  = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      lat = i + 1;
      if (sum_valid) begin
        seen = 1;
        break;
      end
    end
    if (!seen) chk({nm, "_timeout"}, 0, 1);
    chk(nm, sum, exp);
    chk({nm, "_model"}, m_sum, exp);
  endtask

  initial begin
    int lat;
    logic [7:0] held;
    logic [6:0] c[4];

    repeat (3) @(posedge clk);
    #1 cmp_en = 1'b1;
    @(negedge clk);
    chk("rst_ready", char_ready, 0);
    chk("rst_sum", sum, 0);
    chk("rst_conv_ad", conv_ad, 7'h30);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_release", char_ready, 1);

    // T1
    send4(7'h34, 7'h32, 7'h31, 7'h37, 0);
    wait_sum("t1_sum", 8'd59, lat);
    chk("t1_latency", lat, 2 * CONV_WAIT + 2);
`ifdef SUM_ASCII_EN
    chk("t1_ascii_h", asc_h, 7'h30);
    chk("t1_ascii_t", asc_t, 7'h35);
    chk("t1_ascii_u", asc_u, 7'h39);
`endif

    // T2 extremes
    send4(7'h39, 7'h39, 7'h39, 7'h39, 0);
    wait_sum("t2_max", 8'hC6, lat);
`ifdef SUM_ASCII_EN
    chk("t2_ascii_h", asc_h, 7'h31);
    chk("t2_ascii_t", asc_t, 7'h39);
    chk("t2_ascii_u", asc_u, 7'h38);
`endif
    send4(7'h30, 7'h30, 7'h30, 7'h30, 0);
    wait_sum("t2_min", 8'd0, lat);

    // T3 illegal character restarts collection
    send_char(7'h33, 0);
    send_char(7'h41, 0);
    @(negedge clk);
    chk("t3_err_pulse", char_err, 1);
    @(negedge clk);
    chk("t3_err_clear", char_err, 0);
    send4(7'h31, 7'h32, 7'h30, 7'h35, 0);
    wait_sum("t3_sum", 8'd17, lat);

    // T4 downstream backpressure
    @(posedge clk); #1 rdy_mode = 2;
    @(posedge clk); #1;
    send4(7'h35, 7'h35, 7'h34, 7'h34, 0);
    wait_sum("t4_sum", 8'd99, lat);
    char_valid = 1'b1;
    char_in    = 7'h37;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t4_hold_sum", sum, 8'd99);
      chk("t4_hold_ready", char_ready, 0);
    end
    @(posedge clk); #1 char_valid = 1'b0; rdy_mode = 1;
    @(posedge clk); #1;

    // T5 reset during CONV_B
    send4(7'h30, 7'h38, 7'h30, 7'h39, 0);
    @(posedge clk); #1 rst_n = 1'b0;
    #1;
    chk("t5_sum", sum, 0);
    chk("t5_valid", sum_valid, 0);
    chk("t5_ready", char_ready, 0);
    chk("t5_conv_au", conv_au, 7'h30);
    @(posedge clk); #1 rst_n = 1'b1;
    send4(7'h30, 7'h31, 7'h30, 7'h31, 0);
    wait_sum("t5_sum_after", 8'd2, lat);

    // T6 gapped input and back-to-back results
    send4(7'h31, 7'h32, 7'h33, 7'h34, 2);
    wait_sum("t6_first", 8'd46, lat);
    send4(7'h39, 7'h38, 7'h37, 7'h36, 0);
    wait_sum("t6_second", 8'd174, lat);
    held = sum;
    send4(7'h32, 7'h30, 7'h30, 7'h35, 0);
    wait_sum("t6_third", 8'd25, lat);
    chk("t6_changed", held == sum, 0);

    // Random traffic with occasional illegal characters
    @(posedge clk); #1 rdy_mode = 0;
    for (int t = 0; t < 40; t++) begin
      for (int k = 0; k < 4; k++) begin
        if ($urandom_range(0, 15) == 0) begin
          do c[k] = 7'($urandom_range(0, 127));
          while (is_digit(c[k]));
        end else begin
          c[k] = 7'(48 + $urandom_range(0, 9));
        end
        send_char(c[k], $urandom_range(0, 2));
      end
    end
    repeat (20) @(posedge clk);
    #1 rdy_mode = 1;
    repeat (5) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
